// File: rtl/lobster_mmu_pkg.sv
// Shared types and page-entry field layout for the lobster TLB MMU.
// Entry word: [0] V, [1] R, [2] W, [3] X, [4] U, [7:5] reserved, [35:8] VPN, [63:36] PPN.
package lobster_mmu_pkg;

  typedef enum logic [1:0] {
    ACC_READ  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_EXEC  = 2'd2
  } acc_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_MISS = 2'd1,
    CAUSE_PERM = 2'd2
  } cause_t;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_U       = 4;
  localparam int PTE_VPN_LSB = 8;
  localparam int PTE_PPN_LSB = 36;
  localparam int PTE_FIELD_W = 28;

  typedef struct packed {
    logic u;
    logic x;
    logic w;
    logic r;
  } perm_t;

  function automatic perm_t pte_perm(input logic [63:0] pte);
    perm_t p;
    p.u = pte[PTE_U];
    p.x = pte[PTE_X];
    p.w = pte[PTE_W];
    p.r = pte[PTE_R];
    return p;
  endfunction

endpackage

// File: rtl/lobster_tlb_set_array.sv
// TLB entry storage with per-set round-robin replacement; combinational parallel VPN lookup.
// Fill/invalidate take effect at the clock edge, so a same-cycle lookup sees the old contents.
module lobster_tlb_set_array
  import lobster_mmu_pkg::*;
#(
  parameter int VPN_W           = 24,
  parameter int PPN_W           = 24,
  parameter int NUM_TLB_ENTRIES = 64,
  parameter int TLB_WAYS        = 4,
  parameter int WAY_W           = (TLB_WAYS > 1) ? $clog2(TLB_WAYS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inv_all,
  input  logic              i_we,
  input  logic [63:0]       i_page_in,
  input  logic [VPN_W-1:0]  i_lk_vpn,
  output logic              o_hit,
  output logic [WAY_W-1:0]  o_way,
  output perm_t             o_perm,
  output logic [PPN_W-1:0]  o_ppn
);

  localparam int SETS  = NUM_TLB_ENTRIES / TLB_WAYS;
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

  logic [TLB_WAYS-1:0] r_valid [SETS];
  logic [WAY_W-1:0]    r_rr    [SETS];
  logic [VPN_W-1:0]    r_vpn   [SETS][TLB_WAYS];
  logic [PPN_W-1:0]    r_ppn   [SETS][TLB_WAYS];
  perm_t               r_perm  [SETS][TLB_WAYS];

  function automatic logic [SET_W-1:0] set_of(input logic [VPN_W-1:0] vpn);
    if (SETS > 1) return vpn[SET_W-1:0];
    else          return '0;
  endfunction

  logic [SET_W-1:0] w_lk_set;
  logic [SET_W-1:0] w_wr_set;
  logic [VPN_W-1:0] w_wr_vpn;
  logic [PPN_W-1:0] w_wr_ppn;
  logic             w_same;
  logic [WAY_W-1:0] w_same_way;
  logic             w_free;
  logic [WAY_W-1:0] w_free_way;
  logic [WAY_W-1:0] w_fill_way;
  logic             w_bump_rr;
  logic             w_do_write;
  logic             w_unused_page;

  assign w_wr_vpn      = i_page_in[PTE_VPN_LSB +: VPN_W];
  assign w_wr_ppn      = i_page_in[PTE_PPN_LSB +: PPN_W];
  assign w_wr_set      = set_of(w_wr_vpn);
  assign w_lk_set      = set_of(i_lk_vpn);
  assign w_do_write    = i_we && !i_inv_all;
  assign w_unused_page = ^i_page_in;

  // The fill rule keeps VPNs unique within a set, so at most one way can match.
  always_comb begin
    o_hit  = 1'b0;
    o_way  = '0;
    o_perm = '0;
    o_ppn  = '0;
    for (int w = 0; w < TLB_WAYS; w++) begin
      if (r_valid[w_lk_set][w] && (r_vpn[w_lk_set][w] == i_lk_vpn)) begin
        o_hit  = 1'b1;
        o_way  = WAY_W'(w);
        o_perm = r_perm[w_lk_set][w];
        o_ppn  = r_ppn[w_lk_set][w];
      end
    end
  end

  always_comb begin
    w_same     = 1'b0;
    w_same_way = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int w = 0; w < TLB_WAYS; w++) begin
      if (!w_same && r_valid[w_wr_set][w] && (r_vpn[w_wr_set][w] == w_wr_vpn)) begin
        w_same     = 1'b1;
        w_same_way = WAY_W'(w);
      end
      if (!w_free && !r_valid[w_wr_set][w]) begin
        w_free     = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
    w_bump_rr  = !w_same && !w_free;
    w_fill_way = w_same ? w_same_way : (w_free ? w_free_way : r_rr[w_wr_set]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else if (i_inv_all) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
    end else if (i_we) begin
      r_valid[w_wr_set][w_fill_way] <= i_page_in[PTE_V];
      if (w_bump_rr)
        r_rr[w_wr_set] <= (TLB_WAYS > 1) ? r_rr[w_wr_set] + WAY_W'(1) : '0;
    end
  end

  // Payload carries no reset; its valid bit guards every use.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_do_write) begin
      r_vpn[w_wr_set][w_fill_way]  <= w_wr_vpn;
      r_ppn[w_wr_set][w_fill_way]  <= w_wr_ppn;
      r_perm[w_wr_set][w_fill_way] <= pte_perm(i_page_in);
    end
  end

endmodule

// File: rtl/lobster_tlb_mmu.sv
// Set-associative TLB MMU: translates and permission-checks one request per cycle.
// Response registered one cycle after acceptance; req_ready drops while a response is stalled.
module lobster_tlb_mmu
  import lobster_mmu_pkg::*;
#(
  parameter int ADDR_WIDTH      = 36,
  parameter int PAGE_BITS       = 12,
  parameter int NUM_TLB_ENTRIES = 64,
  parameter int TLB_WAYS        = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mmu_en,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_vaddr,
  input  logic [1:0]            i_req_acc,
  input  logic                  i_req_user,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [ADDR_WIDTH-1:0] o_resp_paddr,
  output logic                  o_resp_fault,
  output logic [1:0]            o_resp_cause,
  input  logic                  i_we,
  input  logic [63:0]           i_page_in,
  input  logic                  i_inv_all
);

  localparam int VPN_W = ADDR_WIDTH - PAGE_BITS;
  localparam int PPN_W = VPN_W;
  localparam int WAY_W = (TLB_WAYS > 1) ? $clog2(TLB_WAYS) : 1;

  logic                  r_resp_valid;
  logic [ADDR_WIDTH-1:0] r_resp_paddr;
  logic                  r_resp_fault;
  logic [1:0]            r_resp_cause;

  logic                  w_accept;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_way;
  perm_t                 w_perm;
  logic [PPN_W-1:0]      w_ppn;
  logic                  w_perm_ok;
  logic                  w_acc_ok;
  logic [ADDR_WIDTH-1:0] w_paddr;
  logic                  w_fault;
  logic [1:0]            w_cause;
  logic                  w_unused_way;

  assign o_req_ready  = !r_resp_valid || i_resp_ready;
  assign w_accept     = i_req_valid && o_req_ready;
  assign w_unused_way = ^w_way;

  lobster_tlb_set_array #(
    .VPN_W           (VPN_W),
    .PPN_W           (PPN_W),
    .NUM_TLB_ENTRIES (NUM_TLB_ENTRIES),
    .TLB_WAYS        (TLB_WAYS),
    .WAY_W           (WAY_W)
  ) u_set_array (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inv_all (i_inv_all),
    .i_we      (i_we),
    .i_page_in (i_page_in),
    .i_lk_vpn  (i_req_vaddr[ADDR_WIDTH-1:PAGE_BITS]),
    .o_hit     (w_hit),
    .o_way     (w_way),
    .o_perm    (w_perm),
    .o_ppn     (w_ppn)
  );

  // Reserved access code 3 falls through to the read check; supervisor may touch U pages.
  always_comb begin
    if (i_req_acc == ACC_WRITE)     w_acc_ok = w_perm.w;
    else if (i_req_acc == ACC_EXEC) w_acc_ok = w_perm.x;
    else                            w_acc_ok = w_perm.r;
    w_perm_ok = w_acc_ok && (!i_req_user || w_perm.u);
  end

  always_comb begin
    w_paddr = '0;
    w_fault = 1'b0;
    w_cause = CAUSE_NONE;
    if (!i_mmu_en) begin
      w_paddr = i_req_vaddr;
    end else if (!w_hit) begin
      w_fault = 1'b1;
      w_cause = CAUSE_MISS;
    end else if (!w_perm_ok) begin
      w_fault = 1'b1;
      w_cause = CAUSE_PERM;
    end else begin
      w_paddr = {w_ppn, i_req_vaddr[PAGE_BITS-1:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_resp_valid <= 1'b0;
      r_resp_paddr <= '0;
      r_resp_fault <= 1'b0;
      r_resp_cause <= CAUSE_NONE;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_paddr <= w_paddr;
      r_resp_fault <= w_fault;
      r_resp_cause <= w_cause;
    end else if (i_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_paddr = r_resp_paddr;
  assign o_resp_fault = r_resp_fault;
  assign o_resp_cause = r_resp_cause;

endmodule

// File: tb/tb_lobster_tlb_mmu.sv
// Directed vector bench for lobster_tlb_mmu: translation tables plus stall, eviction,
// invalidate-collision and reset-drop sequences.
module tb_lobster_tlb_mmu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmu_en;
  logic        req_valid;
  logic        req_ready;
  logic [35:0] req_vaddr;
  logic [1:0]  req_acc;
  logic        req_user;
  logic        resp_valid;
  logic        resp_ready;
  logic [35:0] resp_paddr;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic        we;
  logic [63:0] page_in;
  logic        inv_all;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lobster_tlb_mmu dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_mmu_en     (mmu_en),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_vaddr  (req_vaddr),
    .i_req_acc    (req_acc),
    .i_req_user   (req_user),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_paddr (resp_paddr),
    .o_resp_fault (resp_fault),
    .o_resp_cause (resp_cause),
    .i_we         (we),
    .i_page_in    (page_in),
    .i_inv_all    (inv_all)
  );

  typedef struct {
    logic        en;
    logic [1:0]  acc;
    logic        usr;
    logic [35:0] va;
    logic        flt;
    logic [1:0]  cause;
    logic [35:0] pa;
  } vec_t;

  vec_t tab1[8];
  vec_t tab2[5];

  function automatic vec_t mk(input logic en, input logic [1:0] acc, input logic usr,
                              input logic [35:0] va, input logic flt,
                              input logic [1:0] cause, input logic [35:0] pa);
    vec_t v;
    v.en = en; v.acc = acc; v.usr = usr; v.va = va;
    v.flt = flt; v.cause = cause; v.pa = pa;
    return v;
  endfunction

  function automatic logic [35:0] va_of(input logic [23:0] vpn, input logic [11:0] off);
    return {vpn, off};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr_page(input logic [23:0] vpn, input logic [23:0] ppn, input logic [4:0] flags);
    @(negedge clk);
    we      = 1'b1;
    page_in = (64'(ppn) << 36) | (64'(vpn) << 8) | 64'(flags);
    @(negedge clk);
    we      = 1'b0;
  endtask

  // Issues one request; returns at the following negedge with the response on the outputs.
  task automatic do_req(input logic en, input logic [1:0] acc, input logic usr, input logic [35:0] va);
    @(negedge clk);
    mmu_en    = en;
    req_acc   = acc;
    req_user  = usr;
    req_vaddr = va;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    do_req(v.en, v.acc, v.usr, v.va);
    check({tag, "_valid"}, 64'(resp_valid), 64'(1'b1));
    check({tag, "_fault"}, 64'(resp_fault), 64'(v.flt));
    check({tag, "_cause"}, 64'(resp_cause), 64'(v.cause));
    check({tag, "_paddr"}, 64'(resp_paddr), 64'(v.pa));
  endtask

  initial begin
    rst = 1'b1; mmu_en = 1'b1; req_valid = 1'b0; req_vaddr = '0; req_acc = 2'd0;
    req_user = 1'b0; resp_ready = 1'b1; we = 1'b0; page_in = '0; inv_all = 1'b0;

    tab1[0] = mk(1, 2'd0, 0, 36'h0_1234_5678, 0, 2'd0, 36'h0_ABCD_E678);
    tab1[1] = mk(1, 2'd1, 0, 36'h0_1234_5678, 0, 2'd0, 36'h0_ABCD_E678);
    tab1[2] = mk(1, 2'd2, 0, 36'h0_1234_5678, 1, 2'd2, 36'h0);
    tab1[3] = mk(1, 2'd0, 1, 36'h0_1234_5678, 1, 2'd2, 36'h0);
    tab1[4] = mk(1, 2'd3, 0, 36'h0_1234_5FFF, 0, 2'd0, 36'h0_ABCD_EFFF);
    tab1[5] = mk(1, 2'd0, 0, 36'h0_1234_6000, 1, 2'd1, 36'h0);
    tab1[6] = mk(0, 2'd1, 0, 36'hF_FFFF_FFFF, 0, 2'd0, 36'hF_FFFF_FFFF);
    tab1[7] = mk(0, 2'd2, 1, 36'h0_1234_6ABC, 0, 2'd0, 36'h0_1234_6ABC);

    tab2[0] = mk(1, 2'd0, 0, va_of(24'h10, 12'h001), 1, 2'd1, 36'h0);
    tab2[1] = mk(1, 2'd2, 1, va_of(24'h20, 12'h002), 0, 2'd0, 36'h0_0010_1002);
    tab2[2] = mk(1, 2'd1, 1, va_of(24'h30, 12'h003), 0, 2'd0, 36'h0_0077_7003);
    tab2[3] = mk(1, 2'd0, 0, va_of(24'h40, 12'h004), 0, 2'd0, 36'h0_0010_3004);
    tab2[4] = mk(1, 2'd0, 0, va_of(24'h50, 12'h005), 0, 2'd0, 36'h0_0010_4005);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 64'(resp_valid), 64'(0));
    check("rst_fault", 64'(resp_fault), 64'(0));
    check("rst_cause", 64'(resp_cause), 64'(0));
    check("rst_paddr", 64'(resp_paddr), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(1));

    run_vec(mk(1, 2'd0, 0, 36'h0_1234_5678, 1, 2'd1, 36'h0), "cold_miss");

    wr_page(24'h012345, 24'h0ABCDE, 5'b00111);
    for (int i = 0; i < 8; i++) run_vec(tab1[i], $sformatf("t1_%0d", i));

    // Five VPNs into set 0: fifth replaces way 0 (0x10), pointer advances to 1.
    for (int i = 0; i < 5; i++) wr_page(24'((i + 1) * 16), 24'(12'h100 + i), 5'h1F);
    // Rewrite of resident 0x30 must reuse its own way, not the pointer way (0x20).
    wr_page(24'h30, 24'h777, 5'h1F);
    for (int i = 0; i < 5; i++) run_vec(tab2[i], $sformatf("t2_%0d", i));
    wr_page(24'h60, 24'h105, 5'h1F);
    run_vec(mk(1, 2'd0, 0, va_of(24'h20, 12'h00F), 1, 2'd1, 36'h0), "rr_evict_20");
    run_vec(mk(1, 2'd0, 0, va_of(24'h60, 12'h006), 0, 2'd0, 36'h0_0010_5006), "rr_new_60");
    wr_page(24'h40, 24'h103, 5'h1E);
    run_vec(mk(1, 2'd0, 0, va_of(24'h40, 12'h004), 1, 2'd1, 36'h0), "unmap_40");

    // Stall the response for three cycles with a second request waiting.
    @(negedge clk);
    resp_ready = 1'b0; mmu_en = 1'b1; req_acc = 2'd0; req_user = 1'b0;
    req_vaddr = 36'h0_1234_5678; req_valid = 1'b1;
    @(negedge clk);
    check("bp_valid", 64'(resp_valid), 64'(1));
    req_vaddr = va_of(24'h50, 12'h0AA);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_ready_%0d", i), 64'(req_ready), 64'(0));
      check($sformatf("bp_hold_%0d", i), 64'(resp_paddr), 64'h0_ABCD_E678);
      @(negedge clk);
    end
    check("bp_hold_end", 64'(resp_paddr), 64'h0_ABCD_E678);
    resp_ready = 1'b1;
    #1 check("bp_release_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    check("bp_b_valid", 64'(resp_valid), 64'(1));
    check("bp_b_paddr", 64'(resp_paddr), 64'h0_0010_40AA);
    req_vaddr = va_of(24'h60, 12'h0BB);
    @(negedge clk);
    check("bp_c_valid", 64'(resp_valid), 64'(1));
    check("bp_c_paddr", 64'(resp_paddr), 64'h0_0010_50BB);
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_drain", 64'(resp_valid), 64'(0));

    // Lookup colliding with inv_all+we sees old state; the write is dropped.
    @(negedge clk);
    req_vaddr = 36'h0_1234_5678; req_acc = 2'd0; req_valid = 1'b1;
    inv_all = 1'b1; we = 1'b1;
    page_in = (64'(24'h222) << 36) | (64'(24'h99) << 8) | 64'h1F;
    @(negedge clk);
    req_valid = 1'b0; inv_all = 1'b0; we = 1'b0;
    check("inv_same_fault", 64'(resp_fault), 64'(0));
    check("inv_same_paddr", 64'(resp_paddr), 64'h0_ABCD_E678);
    run_vec(mk(1, 2'd0, 0, 36'h0_1234_5678, 1, 2'd1, 36'h0), "inv_after");
    run_vec(mk(1, 2'd0, 0, va_of(24'h99, 12'h123), 1, 2'd1, 36'h0), "inv_dropped_we");

    // Reset with a stalled response pending.
    wr_page(24'h50, 24'h104, 5'h1F);
    @(negedge clk);
    resp_ready = 1'b0; mmu_en = 1'b0; req_vaddr = 36'h0_0000_0123; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_pre_valid", 64'(resp_valid), 64'(1));
    check("rstmid_pre_paddr", 64'(resp_paddr), 64'h123);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; resp_ready = 1'b1;
    check("rstmid_valid", 64'(resp_valid), 64'(0));
    check("rstmid_paddr", 64'(resp_paddr), 64'(0));
    check("rstmid_ready", 64'(req_ready), 64'(1));
    run_vec(mk(1, 2'd0, 0, va_of(24'h50, 12'h005), 1, 2'd1, 36'h0), "rstmid_flushed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lobster_tlb_mmu.md
Name: lobster_tlb_mmu

Overview:
- Parametrised, set-associative TLB-based MMU. Translates a virtual address to a physical address with a valid/ready request handshake and a registered response.
- Checks read/write/execute/user permissions and reports miss and permission faults.
- Supports software refill through a 64-bit page-entry write port, plus global invalidate and a translation-disable bypass.
- Sits between the core load/store/fetch path and the cache (lobster cache).

Parameters:
- ADDR_WIDTH, 36, virtual and physical address width.
- PAGE_BITS, 12, page offset width. VPN_W = PPN_W = ADDR_WIDTH-PAGE_BITS, which must be <= 28.
- NUM_TLB_ENTRIES, 64, total entries; power of two, multiple of TLB_WAYS.
- TLB_WAYS, 4, associativity; power of two, >= 1. SETS = NUM_TLB_ENTRIES/TLB_WAYS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mmu_en  in  1  1 = translate; 0 = identity mapping, no faults.
- req_valid  in  1  translation request.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_vaddr  in  ADDR_WIDTH  virtual address.
- req_acc  in  2  access type: 0 read, 1 write, 2 exec, 3 reserved (treated as read).
- req_user  in  1  1 = user-mode access.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_paddr  out  ADDR_WIDTH  physical address (0 when fault).
- resp_fault  out  1  translation failed.
- resp_cause  out  2  0 none, 1 miss, 2 permission.
- we  in  1  write page_in into TLB.
- page_in  in  64  entry: [0] V, [1] R, [2] W, [3] X, [4] U, [7:5] reserved, [35:8] VPN (low VPN_W bits used), [63:36] PPN (low PPN_W bits used).
- inv_all  in  1  invalidate every entry.

Behaviour:
- Reset: all entry valid bits = 0; round-robin pointers = 0; resp_valid = 0, resp_fault = 0, resp_cause = 0, resp_paddr = 0. req_ready = 1 from the first cycle after reset.
- req_ready = !resp_valid || resp_ready (single-stage skid-free pipeline, full throughput).
- Latency: accept in cycle N, response registered and visible in cycle N+1.
- resp_* hold stable while resp_valid && !resp_ready.
- Lookup:
  - set = VPN[log2(SETS)-1:0]; compare full VPN against every valid way in parallel.
  - More than one matching way cannot occur (see fill rule).
- Hit checks:
  - Permission fault if req_user && !U, or acc read && !R, or acc write && !W, or acc exec && !X. Supervisor may access U pages.
  - No fault: paddr = {PPN, vaddr[PAGE_BITS-1:0]}, cause 0.
- Miss: resp_fault = 1, cause 1, paddr 0. Block does not walk page tables; software refills via we.
- mmu_en = 0: paddr = vaddr, fault 0, cause 0, same one-cycle latency. mmu_en is sampled at request acceptance.
- Fill (we = 1):
  - Target set from page_in VPN.
  - If a valid way in the set holds the same VPN, overwrite that way.
  - Otherwise use the lowest-index invalid way.
  - Otherwise use the way at the set's round-robin pointer, then increment the pointer modulo TLB_WAYS.
  - A page_in with V = 0 is written as-is, so writing V = 0 for an existing VPN unmaps that page.
- Priority in one cycle: rst > inv_all > we. inv_all with we: the write is dropped.
- Lookup accepted in the same cycle as we/inv_all observes pre-update TLB state; the update is visible to requests accepted from the next cycle.
- rst mid-operation drops any pending response (resp_valid = 0 next cycle).
- Reserved/unused upper VPN/PPN bits in page_in are ignored.

Decomposition:
- Package lobster_mmu_pkg:
  - acc_t enum (ACC_READ/WRITE/EXEC).
  - cause_t enum (CAUSE_NONE/MISS/PERM).
  - flag bit indices PTE_V/R/W/X/U.
  - field offsets PTE_VPN_LSB = 8, PTE_PPN_LSB = 36.
- One sub-module, lobster_tlb_set_array:
  - Holds entry storage and per-set round-robin pointers.
  - Performs the parallel VPN compare, returning hit, way, and flags/PPN.
- The top level owns the handshake, permission check and response register.

Test Plan:
- Reset, then a read of vaddr 0x0_1234_5678 with mmu_en = 1 -> next cycle resp_valid = 1, fault = 1, cause = 1, paddr = 0.
- Write page_in with VPN = 0x012345, PPN = 0x0ABCDE, flags V|R|W; read vaddr 0x0_1234_5678 -> paddr 0x0_ABCD_E678, cause 0. Exec of the same address -> cause 2. User read -> cause 2.
- Fill TLB_WAYS+1 distinct VPNs mapping to set 0 -> first VPN evicted (pointer 0) and misses; the others hit. Rewriting an existing VPN with a new PPN -> no eviction, new PPN returned.
- resp_ready held 0 for 3 cycles with req_valid = 1 -> req_ready = 0, resp_paddr stable; on release, back-to-back responses with one per cycle.
- inv_all and we asserted in the same cycle as a hitting lookup -> that lookup hits; the next lookup misses; the written entry is absent.
- mmu_en = 0, vaddr 0xF_FFFF_FFFF write -> paddr 0xF_FFFF_FFFF, no fault. Assert rst while resp_valid = 1 -> resp_valid = 0 next cycle.
